// File: rtl/tau_to_freq_module.sv
// -----------------------------------------------------------------------------
// tau_to_freq_module
//
// Converts a pitch lag (in samples) into a pitch frequency in Hz by dividing
// SAMPLE_RATE by the lag. A bit-serial restoring divider produces one
// quotient bit per clock, MSB first.
//
// Each conversion starts on a 0->1 transition of tau_valid. The result appears
// FREQ_WIDTH+1 cycles after the clock edge that captured the lag. Lags below
// MIN_TAU, including 0, still take the full divide time. They report freq=0
// and voiced=0.
//
// Optional feature, selected by the macro MEDIAN_SMOOTH_EN:
//   freq becomes the median of the new result and the two previous results.
//   Unvoiced results enter that window as 0. No latency is added. voiced
//   always follows the raw lag of the current frame.
//
// Ports:
//   clk        in   sole clock; all state changes on the rising edge
//   reset      in   asynchronous, active-low reset
//   tau_valid  in   level from upstream; its rising edge starts a conversion
//   tau        in   [TAU_WIDTH-1:0]  lag in samples (0 = no pitch found)
//   freq       out  [FREQ_WIDTH-1:0] pitch in Hz, truncated; 0 when unvoiced
//   voiced     out  last result came from a lag >= MIN_TAU
//   freq_valid out  one-cycle pulse when freq/voiced update
//   busy       out  high while the divider is iterating
//   overrun    out  sticky; a start arrived while not idle and was dropped
// -----------------------------------------------------------------------------
module tau_to_freq_module #(
    parameter int TAU_WIDTH   = 8,
    parameter int FREQ_WIDTH  = 16,
    parameter int SAMPLE_RATE = 48000,
    parameter int MIN_TAU     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tau_valid,
    input  logic [TAU_WIDTH-1:0]  tau,
    output logic [FREQ_WIDTH-1:0] freq,
    output logic                  voiced,
    output logic                  freq_valid,
    output logic                  busy,
    output logic                  overrun
);

    localparam int                    CNT_W     = $clog2(FREQ_WIDTH);
    localparam logic [CNT_W-1:0]      CNT_INIT  = CNT_W'(FREQ_WIDTH - 1);
    localparam logic [FREQ_WIDTH-1:0] DIVIDEND  = FREQ_WIDTH'(SAMPLE_RATE);
    localparam logic [TAU_WIDTH:0]    MIN_TAU_W = (TAU_WIDTH + 1)'(MIN_TAU);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                  state_q;
    logic                    tau_valid_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [FREQ_WIDTH:0]     rem_q;
    logic [FREQ_WIDTH:0]     div_q;
    logic [FREQ_WIDTH-1:0]   quo_q;
    logic                    vraw_q;
    logic [FREQ_WIDTH-1:0]   freq_q;
    logic                    voiced_q;
    logic                    freq_valid_q;
    logic                    busy_q;
    logic                    overrun_q;

    logic                    start;
    logic [FREQ_WIDTH:0]     trial;
    logic [FREQ_WIDTH:0]     rem_d;
    logic                    qbit;
    logic [FREQ_WIDTH-1:0]   result;

`ifdef MEDIAN_SMOOTH_EN
    // The two previous results. Together with the new result they form the
    // 3-entry window for the median.
    logic [FREQ_WIDTH-1:0]   hist_q [2];

    function automatic logic [FREQ_WIDTH-1:0] med3(
        input logic [FREQ_WIDTH-1:0] a,
        input logic [FREQ_WIDTH-1:0] b,
        input logic [FREQ_WIDTH-1:0] c
    );
        logic [FREQ_WIDTH-1:0] lo;
        logic [FREQ_WIDTH-1:0] hi;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        // The median is the larger of min(a,b) and min(max(a,b), c).
        if (c < hi) hi = c;
        return (lo > hi) ? lo : hi;
    endfunction
`endif

    assign start = tau_valid & ~tau_valid_d;

    // One restoring step: shift in the next dividend bit, then subtract the
    // divisor if it fits. The remainder stays below the divisor, so its top
    // bit is 0 in practice. It is still honoured as "definitely fits".
    always_comb begin
        trial = {rem_q[FREQ_WIDTH-1:0], DIVIDEND[cnt_q]};
        rem_d = trial;
        qbit  = 1'b0;
        if (rem_q[FREQ_WIDTH] || (trial >= div_q)) begin
            rem_d = trial - div_q;
            qbit  = 1'b1;
        end
    end

    assign result = vraw_q ? quo_q : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            tau_valid_d  <= 1'b0;
            cnt_q        <= '0;
            rem_q        <= '0;
            div_q        <= '0;
            quo_q        <= '0;
            vraw_q       <= 1'b0;
            freq_q       <= '0;
            voiced_q     <= 1'b0;
            freq_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef MEDIAN_SMOOTH_EN
            hist_q[0]    <= '0;
            hist_q[1]    <= '0;
`endif
        end else begin
            tau_valid_d  <= tau_valid;
            freq_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        div_q   <= (FREQ_WIDTH + 1)'(tau);
                        vraw_q  <= ({1'b0, tau} >= MIN_TAU_W);
                        cnt_q   <= CNT_INIT;
                        rem_q   <= '0;
                        quo_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    if (start) overrun_q <= 1'b1;
                    rem_q <= rem_d;
                    quo_q <= {quo_q[FREQ_WIDTH-2:0], qbit};
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (start) overrun_q <= 1'b1;
`ifdef MEDIAN_SMOOTH_EN
                    freq_q    <= med3(result, hist_q[0], hist_q[1]);
                    hist_q[0] <= result;
                    hist_q[1] <= hist_q[0];
`else
                    freq_q    <= result;
`endif
                    voiced_q     <= vraw_q;
                    freq_valid_q <= 1'b1;
                    state_q      <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign freq       = freq_q;
    assign voiced     = voiced_q;
    assign freq_valid = freq_valid_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_tau_to_freq_module.sv
module tb_tau_to_freq_module;

    logic        clk;
    logic        reset;
    logic        tau_valid;
    logic [7:0]  tau;
    logic [15:0] freq;
    logic        voiced;
    logic        freq_valid;
    logic        busy;
    logic        overrun;

    tau_to_freq_module dut (
        .clk        (clk),
        .reset      (reset),
        .tau_valid  (tau_valid),
        .tau        (tau),
        .freq       (freq),
        .voiced     (voiced),
        .freq_valid (freq_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] f;
        logic        v;
        int          c;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          pushed = 0;
    int          pulses = 0;
    logic [15:0] last_f = 16'd0;
    logic [15:0] h0 = 16'd0;
    logic [15:0] h1 = 16'd0;

    always @(posedge clk) cyc++;

    // Bench-side view of what freq should read, given the raw quotient.
    function automatic logic [15:0] model(input logic [15:0] raw, input logic v);
        logic [15:0] n;
        n = v ? raw : 16'd0;
`ifdef MEDIAN_SMOOTH_EN
        begin
            logic [15:0] s0, s1, s2, t;
            s0 = n; s1 = h0; s2 = h1;
            if (s0 > s1) begin t = s0; s0 = s1; s1 = t; end
            if (s1 > s2) begin t = s1; s1 = s2; s2 = t; end
            if (s0 > s1) begin t = s0; s0 = s1; s1 = t; end
            h1 = h0;
            h0 = n;
            return s1;
        end
`else
        return n;
`endif
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push(input logic [15:0] raw, input logic v);
        exp_t e;
        e.f = model(raw, v);
        e.v = v;
        e.c = cyc + 18;
        sb.push_back(e);
        pushed++;
    endtask

    // Monitor: pops and compares whenever the DUT presents a result.
    always @(negedge clk) begin
        if (freq_valid) begin
            pulses++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_freq_valid: got pulse at cycle %0d, expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("freq", int'(freq), int'(e.f));
                check("voiced", int'(voiced), int'(e.v));
                check("latency_cycle", cyc, e.c);
                last_f = e.f;
            end
        end
    end

    task automatic issue(input logic [7:0] t, input logic [15:0] raw, input logic v);
        @(negedge clk);
        tau       = t;
        tau_valid = 1'b1;
        push(raw, v);
        @(negedge clk);
        tau_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        h0 = 16'd0;
        h1 = 16'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int busy_cnt;
        reset     = 1'b0;
        tau_valid = 1'b0;
        tau       = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_freq", int'(freq), 0);
        check("rst_voiced", int'(voiced), 0);
        check("rst_freq_valid", int'(freq_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overrun", int'(overrun), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // tau=100 with busy-width measurement
        @(negedge clk);
        tau       = 8'd100;
        tau_valid = 1'b1;
        push(16'd480, 1'b1);
        busy_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            tau_valid = 1'b0;
            if (busy) busy_cnt++;
        end
        check("busy_width", busy_cnt, 16);
        wait_done();

        issue(8'd37, 16'd1297, 1'b1);
        wait_done();
        repeat (5) @(negedge clk);
        check("freq_hold", int'(freq), int'(last_f));
        issue(8'd1, 16'd0, 1'b0);
        wait_done();
        issue(8'd2, 16'd24000, 1'b1);
        wait_done();
        issue(8'd0, 16'd0, 1'b0);
        wait_done();
        issue(8'd255, 16'd188, 1'b1);
        wait_done();
        check("overrun_clear", int'(overrun), 0);

        // second rising edge during a conversion is dropped
        issue(8'd100, 16'd480, 1'b1);
        repeat (3) @(negedge clk);
        tau       = 8'd7;
        tau_valid = 1'b1;
        @(negedge clk);
        tau_valid = 1'b0;
        @(negedge clk);
        check("overrun_set", int'(overrun), 1);
        wait_done();
        check("overrun_sticky", int'(overrun), 1);

        // reset mid-conversion
        @(negedge clk);
        tau       = 8'd100;
        tau_valid = 1'b1;
        repeat (8) @(negedge clk);
        check("mid_busy", int'(busy), 1);
        reset = 1'b0;
        h0 = 16'd0;
        h1 = 16'd0;
        #1;
        check("arst_freq", int'(freq), 0);
        check("arst_voiced", int'(voiced), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_overrun", int'(overrun), 0);
        check("arst_freq_valid", int'(freq_valid), 0);
        tau = 8'd50;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        push(16'd960, 1'b1);
        wait_done();
        tau_valid = 1'b0;
        repeat (2) @(negedge clk);

        // level held high for 100 cycles yields a single conversion
        @(negedge clk);
        tau       = 8'd3;
        tau_valid = 1'b1;
        push(16'd16000, 1'b1);
        repeat (100) @(negedge clk);
        tau_valid = 1'b0;
        wait_done();

        // smoothing sequence from a clean history
        do_reset();
        issue(8'd100, 16'd480, 1'b1);
        wait_done();
        issue(8'd100, 16'd480, 1'b1);
        wait_done();
        issue(8'd50, 16'd960, 1'b1);
        wait_done();
        issue(8'd0, 16'd0, 1'b0);
        wait_done();

        check("pulse_count", pulses, pushed);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1);
    end

endmodule
